integer_array_loader: RTL and testbench
=======================================

INTEGER_ARRAY_LOADER -- requirements
Module: integer_array_loader

Interface
REQ-001 SHALL have parameter num_pixel, default 8, meaning interpolated block width; only 8 is supported.
REQ-002 SHALL have parameter integer_rows, default num_pixel+7 (15), meaning reference rows and columns held.
REQ-003 SHALL have parameter integer_cols, default (num_pixel+7)*2 (30), meaning number of sel codes emitted per block.
REQ-004 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port pixel_in, input, 8, integer reference pixel in raster order (column fastest).
REQ-007 SHALL have port pixel_valid, input, 1, pixel_in is valid this cycle.
REQ-008 SHALL have port pixel_ready, output, 1, loader accepts a pixel this cycle.
REQ-009 SHALL have port integer_array, output, 1800, packed 15x15 pixel block for the row/column mux.
REQ-010 SHALL have port sel, output, 8, row/column select code for the mux.
REQ-011 SHALL have port sel_valid, output, 1, sel is valid this cycle.
REQ-012 SHALL have port sel_ready, input, 1, consumer takes sel this cycle.

Function
REQ-013 SHALL implement two states: LOAD and SCAN.
REQ-014 Pixel transfer: SHALL occur on a cycle where pixel_valid and pixel_ready are both 1.
REQ-015 pixel_ready SHALL be 1 exactly when state is LOAD.
REQ-016 Pixel placement: the k-th accepted pixel (k = 0..224) SHALL be written at integer_array bits [120*r + 8*c +: 8], with r = k/15 and c = k mod 15.
REQ-017 SHALL keep an 8-bit pixel counter that increments per transfer.
REQ-018 When the transfer with counter = 224 occurs, the counter SHALL clear to 0 and state SHALL become SCAN on the next cycle.
REQ-019 pixel_valid SHALL be ignored in SCAN; the array and counter SHALL not change.
REQ-020 In SCAN, sel_valid SHALL be 1 and sel SHALL start at 0.
REQ-021 In SCAN, sel SHALL increment by 1 on each cycle where sel_valid and sel_ready are both 1.
REQ-022 When sel = 29 is accepted, sel SHALL clear to 0, sel_valid SHALL drop, and state SHALL return to LOAD on the next cycle.
REQ-023 With sel_ready low, sel and sel_valid SHALL hold.
REQ-024 integer_array SHALL be stable for the whole of SCAN.
REQ-025 In LOAD, integer_array SHALL be overwritten pixel by pixel; unwritten positions keep the prior block's values.
REQ-026 Minimum block period SHALL be 225 + 30 cycles; there SHALL be no idle cycle between SCAN exit and the first LOAD transfer.
REQ-027 All outputs SHALL be registered or decoded from state registers only; there SHALL be no combinational path from pixel_valid or sel_ready to any output.

Reset
REQ-028 While reset is 1 at a clock edge: state SHALL become LOAD, pixel counter SHALL become 0, integer_array SHALL become all zeros, sel SHALL become 0, and sel_valid SHALL become 0.
REQ-029 pixel_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-030 Reset asserted mid-LOAD or mid-SCAN SHALL abort the block; the next accepted pixel SHALL be stored as k = 0.
REQ-031 A pixel_valid coincident with reset SHALL be discarded.

Verification
REQ-032 After reset, stream 225 pixels with value k mod 256 and pixel_valid held high -> bits [7:0]=0x00, [127:120]=0x0F, [1799:1792]=0xE0; SCAN entered the cycle after pixel 224.
REQ-033 Same stream with pixel_valid toggling 1,0,1,0 -> identical final integer_array; counter advances only on transfers.
REQ-034 In SCAN with sel_ready=1 -> sel = 0,1,...,29 on 30 consecutive cycles, then pixel_ready=1 on the next cycle.
REQ-035 In SCAN with sel_ready low for 3 cycles at sel=7 -> sel=7 held, then resumes at 8.
REQ-036 pixel_valid=1 with pixel_in=0xFF throughout SCAN -> pixel_ready=0 and integer_array unchanged.
REQ-037 Reset after 100 pixels -> integer_array all zeros; a fresh 225-pixel stream then yields REQ-032 values.

Source files
------------

// File: rtl/integer_array_loader_if.sv
// ---------------------------------------------------------------------------
// integer_array_loader_if
// Groups the two handshakes of the integer array loader and its block output.
//   pixel_in/pixel_valid/pixel_ready : raster-order reference pixel stream in
//   integer_array                    : packed integer_rows x integer_rows block
//   sel/sel_valid/sel_ready          : row/column select code stream out
// master : the pixel producer / sel consumer (drives pixel_*, sel_ready)
// slave  : the loader itself
// ---------------------------------------------------------------------------
interface integer_array_loader_if #(
  parameter int num_pixel    = 8,
  parameter int integer_rows = num_pixel + 7
);
  localparam int array_w = integer_rows * integer_rows * 8;

  logic [7:0]         pixel_in;
  logic               pixel_valid;
  logic               pixel_ready;
  logic [array_w-1:0] integer_array;
  logic [7:0]         sel;
  logic               sel_valid;
  logic               sel_ready;

  modport master (
    output pixel_in, pixel_valid, sel_ready,
    input  pixel_ready, integer_array, sel, sel_valid
  );

  modport slave (
    input  pixel_in, pixel_valid, sel_ready,
    output pixel_ready, integer_array, sel, sel_valid
  );
endinterface

// File: rtl/integer_array_loader.sv
// ---------------------------------------------------------------------------
// integer_array_loader
// Collects one integer_rows x integer_rows block of 8-bit reference pixels
// (raster order, column fastest) into a packed array, then emits integer_cols
// row/column select codes for the downstream mux while holding the block.
//   clock : single clock, rising edge
//   reset : synchronous, active high; aborts any block in progress
//   bus   : slave side of integer_array_loader_if
//             pixel_in/pixel_valid/pixel_ready -> pixel stream (LOAD only)
//             integer_array                    -> packed block, 8 bits/pixel
//             sel/sel_valid/sel_ready          -> select codes (SCAN only)
// All outputs come straight from flops or from a decode of the state flop.
// ---------------------------------------------------------------------------
module integer_array_loader #(
  parameter int num_pixel    = 8,
  parameter int integer_rows = num_pixel + 7,
  parameter int integer_cols = (num_pixel + 7) * 2
) (
  input  logic                  clock,
  input  logic                  reset,
  integer_array_loader_if.slave bus
);

  localparam int array_w = integer_rows * integer_rows * 8;
  localparam logic [7:0] last_pixel = 8'(integer_rows * integer_rows - 1);
  localparam logic [7:0] last_sel   = 8'(integer_cols - 1);

  typedef enum logic {
    LOAD = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [7:0]         sel_q, sel_d;
  logic [array_w-1:0] array_q, array_d;

  logic pixel_fire;
  logic sel_fire;

  // Handshake qualifiers depend only on the state flop and the partner's
  // valid/ready, so no input reaches an output combinationally.
  assign pixel_fire = (state_q == LOAD) && bus.pixel_valid;
  assign sel_fire   = (state_q == SCAN) && bus.sel_ready;

  // State and datapath registers.
  // NOTE: the block array is reset like any other flop because the block
  // must read as all zeros after reset; it is a register bank, not a RAM.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      sel_q   <= '0;
      array_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      array_q <= array_d;
    end
  end

  // Next-state logic.
  // NOTE: every variable gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD: if (pixel_fire && (cnt_q == last_pixel)) state_d = SCAN;
      SCAN: if (sel_fire && (sel_q == last_sel))     state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // Counter, select code and array update.
  // Pixel k lands at 120*(k/15) + 8*(k%15) = 8*k, so the byte offset is the
  // counter itself and no row/column split is needed.
  always_comb begin
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    array_d = array_q;
    if (pixel_fire) begin
      array_d[{cnt_q, 3'b000} +: 8] = bus.pixel_in;
      cnt_d = (cnt_q == last_pixel) ? 8'd0 : cnt_q + 8'd1;
    end
    if (sel_fire) begin
      sel_d = (sel_q == last_sel) ? 8'd0 : sel_q + 8'd1;
    end
  end

  // Outputs: registered values and a decode of the state flop.
  always_comb begin
    bus.pixel_ready   = (state_q == LOAD);
    bus.sel_valid     = (state_q == SCAN);
    bus.sel           = sel_q;
    bus.integer_array = array_q;
  end

endmodule

// File: tb/tb_integer_array_loader.sv
// ---------------------------------------------------------------------------
// tb_integer_array_loader
// Scoreboard bench: accepted pixels are queued with their target byte and
// checked against the block once SCAN starts; the expected select codes are
// queued at SCAN entry and popped as the consumer accepts them.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_integer_array_loader;

  localparam int n_pix   = 225;
  localparam int n_sel   = 30;
  localparam int array_w = 1800;

  typedef struct {
    int         idx;
    logic [7:0] val;
  } pix_t;

  logic clock;
  logic reset;

  integer_array_loader_if #(.num_pixel(8)) bus ();

  integer_array_loader #(.num_pixel(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  pix_t               pix_q[$];
  logic [7:0]         sel_q[$];
  logic [array_w-1:0] exp_arr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reset with a coincident valid pixel that must be discarded.
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    bus.pixel_valid = 1'b1;
    bus.pixel_in    = 8'hAA;
    bus.sel_ready   = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    bus.pixel_valid = 1'b0;
    bus.sel_ready   = 1'b0;
    exp_arr = '0;
    pix_q.delete();
    sel_q.delete();
    check("rst_pixel_ready", 32'(bus.pixel_ready), 32'd1);
    check("rst_sel_valid",   32'(bus.sel_valid),   32'd0);
    check("rst_sel",         32'(bus.sel),         32'd0);
    check("rst_array_zero",  32'(bus.integer_array == '0), 32'd1);
  endtask

  // Streams n pixels of value (k+base); with toggle, valid alternates 1,0.
  task automatic load_pixels(input int n, input bit toggle, input int base);
    int k   = 0;
    int cyc = 0;
    bit v;
    while (k < n && cyc < 4 * n_pix) begin
      @(negedge clock);
      check("load_ready", 32'(bus.pixel_ready), 32'd1);
      check("load_sel_valid", 32'(bus.sel_valid), 32'd0);
      v = toggle ? ((cyc % 2) == 0) : 1'b1;
      bus.pixel_valid = v;
      bus.pixel_in    = 8'(k + base);
      @(posedge clock);
      if (v) begin
        pix_q.push_back('{idx: k, val: 8'(k + base)});
        exp_arr[8*k +: 8] = 8'(k + base);
        k++;
      end
      cyc++;
    end
    if (k < n) check("load_timeout", 32'(k), 32'(n));
    @(negedge clock);
    bus.pixel_valid = 1'b0;
  endtask

  // After a full stream: SCAN must be entered and the block must match.
  task automatic check_scan_entry();
    pix_t p;
    check("scan_ready_low", 32'(bus.pixel_ready), 32'd0);
    check("scan_sel_valid", 32'(bus.sel_valid),   32'd1);
    check("scan_sel_start", 32'(bus.sel),         32'd0);
    while (pix_q.size() > 0) begin
      p = pix_q.pop_front();
      check($sformatf("pix%0d", p.idx), 32'(bus.integer_array[8*p.idx +: 8]), 32'(p.val));
    end
    check("array_model", 32'(bus.integer_array == exp_arr), 32'd1);
  endtask

  // Consumes the select codes; stalls 3 cycles at stall_at (negative: none).
  // Throughout SCAN, a 0xFF pixel is offered and must be ignored.
  task automatic scan_block(input int stall_at);
    int stalls = 0;
    int cyc    = 0;
    for (int i = 0; i < n_sel; i++) sel_q.push_back(8'(i));
    bus.pixel_valid = 1'b1;
    bus.pixel_in    = 8'hFF;
    while (sel_q.size() > 0 && cyc < 4 * n_sel) begin
      check("scan_sel_valid_hold", 32'(bus.sel_valid), 32'd1);
      check("scan_pixel_ready",    32'(bus.pixel_ready), 32'd0);
      check("scan_sel",            32'(bus.sel), 32'(sel_q[0]));
      check("scan_array_stable",   32'(bus.integer_array == exp_arr), 32'd1);
      if (int'(sel_q[0]) == stall_at && stalls < 3) begin
        bus.sel_ready = 1'b0;
        stalls++;
      end else begin
        bus.sel_ready = 1'b1;
      end
      @(posedge clock);
      if (bus.sel_ready) void'(sel_q.pop_front());
      @(negedge clock);
      cyc++;
    end
    if (sel_q.size() > 0) check("scan_timeout", 32'(sel_q.size()), 32'd0);
    if (stall_at >= 0) check("scan_stall_count", 32'(stalls), 32'd3);
    bus.sel_ready   = 1'b0;
    bus.pixel_valid = 1'b0;
    check("exit_pixel_ready", 32'(bus.pixel_ready), 32'd1);
    check("exit_sel_valid",   32'(bus.sel_valid),   32'd0);
    check("exit_sel",         32'(bus.sel),         32'd0);
    check("exit_array_kept",  32'(bus.integer_array == exp_arr), 32'd1);
  endtask

  task automatic spot_check_ramp();
    check("byte_0",    32'(bus.integer_array[7:0]),       32'h00);
    check("byte_15",   32'(bus.integer_array[127:120]),   32'h0F);
    check("byte_224",  32'(bus.integer_array[1799:1792]), 32'hE0);
  endtask

  initial begin
    reset           = 1'b1;
    bus.pixel_in    = '0;
    bus.pixel_valid = 1'b0;
    bus.sel_ready   = 1'b0;
    exp_arr         = '0;

    do_reset();

    // Ramp with valid held high, then a scan with a 3-cycle stall at sel 7.
    load_pixels(n_pix, 1'b0, 0);
    check_scan_entry();
    spot_check_ramp();
    scan_block(7);

    // Same ramp with valid toggling; no idle cycle needed after SCAN exit.
    load_pixels(n_pix, 1'b1, 0);
    check_scan_entry();
    spot_check_ramp();
    scan_block(-1);

    // Different values overwrite the whole previous block.
    load_pixels(n_pix, 1'b0, 91);
    check_scan_entry();
    check("byte_0_off",   32'(bus.integer_array[7:0]),       32'd91);
    check("byte_224_off", 32'(bus.integer_array[1799:1792]), 32'(8'(224 + 91)));
    scan_block(0);

    // Partial block aborted by reset, then a fresh ramp starts at k = 0.
    load_pixels(100, 1'b0, 0);
    do_reset();
    load_pixels(n_pix, 1'b0, 0);
    check_scan_entry();
    spot_check_ramp();
    scan_block(29);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
